ula_serial_ctrl: RTL and testbench



---
 rtl/ula_pkg.sv | 26 ++
 rtl/ula_serial_ctrl.sv | 124 ++++++++++++
 tb/tb_ula_serial_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the serial 74181 sequencer: FSM states, nibble width,
// and named function-select codes for the common operations.
// Latency: n/a (definitions only). Backpressure: n/a.
package ula_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of one ula_74181 slice
    localparam int NIBBLE_W = 4;

    // Function-select codes (arithmetic mode meaning: F = A + logic_f(S) + Cin)
    localparam logic [3:0] S_ADD_B    = 4'b1010; // logic_f = B      -> A + B + Cin
    localparam logic [3:0] S_SUB_NOTB = 4'b0101; // logic_f = ~B     -> A - B with Cin=1
    localparam logic [3:0] S_XOR      = 4'b0110; // logic mode A ^ B

    // Nibble-index counter width; at least one bit even for a single nibble
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/ula_serial_ctrl.sv
// Drives one external 4-bit ula_74181 slice a nibble per clock (LSB first) to build a WIDTH-bit ALU op.
// Latency: request accepted in cycle T, rsp_valid first high in cycle T+NIBBLES+1.
// Backpressure: one op in flight; req_ready low from accept until the response handshake completes.
//
// Ports: clk/rst (sync, active-high); req_* request handshake with operands, select, mode and
// carry-in; rsp_* result handshake with WIDTH-bit result, final carry and full-width equality;
// ula_* drive the slice inputs and sample its combinational f/c_out/a_eq_b.
module ula_serial_ctrl
    import ula_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WIDTH-1:0]    req_a,
    input  logic [WIDTH-1:0]    req_b,
    input  logic [3:0]          req_s,
    input  logic                req_m,
    input  logic                req_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_f,
    output logic                rsp_cout,
    output logic                rsp_eq,
    output logic [NIBBLE_W-1:0] ula_a,
    output logic [NIBBLE_W-1:0] ula_b,
    output logic [3:0]          ula_s,
    output logic                ula_m,
    output logic                ula_cin,
    input  logic [NIBBLE_W-1:0] ula_f,
    input  logic                ula_c_out,
    input  logic                ula_a_eq_b
);

    localparam int               IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [3:0]         s_q;
    logic               m_q;
    logic               cin_q;
    logic               carry_q;
    logic               eq_q;
    logic [IDX_W-1:0]   idx_q;

    // Slice inputs: the current nibble while running, all-zero otherwise
    always_comb begin
        ula_a   = '0;
        ula_b   = '0;
        ula_s   = '0;
        ula_m   = 1'b0;
        ula_cin = 1'b0;
        if (state_q == RUN) begin
            ula_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
            ula_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
            ula_s   = s_q;
            ula_m   = m_q;
            // Only the first nibble sees the request carry; later ones chain the slice carry
            ula_cin = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    // Handshake and result outputs come straight from state/registers
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_f     = res_q;
    assign rsp_cout  = carry_q;
    assign rsp_eq    = eq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        s_q     <= req_s;
                        m_q     <= req_m;
                        cin_q   <= req_cin;
                        idx_q   <= '0;
                        eq_q    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[NIBBLE_W*idx_q +: NIBBLE_W] <= ula_f;
                    carry_q <= ula_c_out;
                    eq_q    <= eq_q & ula_a_eq_b;
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Result registers are untouched here, so rsp_* hold under backpressure
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Bench for ula_serial_ctrl with a behavioural 4-bit slice attached to the ula_* ports.
// Latency: n/a. Backpressure: bench holds rsp_ready low on selected operations.
module tb_ula_serial_ctrl;
    import ula_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] f;
        logic         cout;
        logic         eq;
        logic         cin1;   // carry presented to the slice for nibble 1
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_m, req_cin;
    logic [W-1:0] req_a, req_b;
    logic [3:0]   req_s;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_eq;
    logic [W-1:0] rsp_f;
    logic [3:0]   ula_a, ula_b, ula_s, ula_f;
    logic         ula_m, ula_cin, ula_c_out, ula_a_eq_b;

    logic [15:0]  lf16;
    logic [4:0]   sum5;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ula_serial_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_eq(rsp_eq),
        .ula_a(ula_a), .ula_b(ula_b), .ula_s(ula_s), .ula_m(ula_m), .ula_cin(ula_cin),
        .ula_f(ula_f), .ula_c_out(ula_c_out), .ula_a_eq_b(ula_a_eq_b)
    );

    // 74181 logic-mode function table (active-high data), bitwise so usable at any width
    function automatic logic [15:0] lfun(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
        case (s)
            4'b0000: return ~a;
            4'b0001: return ~(a | b);
            4'b0010: return ~a & b;
            4'b0011: return 16'h0000;
            4'b0100: return ~(a & b);
            4'b0101: return ~b;
            4'b0110: return a ^ b;
            4'b0111: return a & ~b;
            4'b1000: return ~a | b;
            4'b1001: return ~(a ^ b);
            4'b1010: return b;
            4'b1011: return a & b;
            4'b1100: return 16'hFFFF;
            4'b1101: return a | ~b;
            4'b1110: return a | b;
            default: return a;
        endcase
    endfunction

    // Behavioural slice: combinational from the controller's ula_* outputs
    always_comb begin
        lf16       = lfun({12'h000, ula_a}, {12'h000, ula_b}, ula_s);
        sum5       = {1'b0, ula_a} + {1'b0, lf16[3:0]} + {4'h0, ula_cin};
        ula_f      = ula_m ? lf16[3:0] : sum5[3:0];
        ula_c_out  = ula_m ? 1'b0 : sum5[4];
        ula_a_eq_b = (ula_a == ula_b);
    end

    // Whole-width reference for one operation
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
        exp_t        e;
        logic [15:0] lf;
        logic [16:0] sum;
        logic [4:0]  lo;
        lf     = lfun(a, b, s);
        sum    = {1'b0, a} + {1'b0, lf} + {16'h0, cin};
        lo     = {1'b0, a[3:0]} + {1'b0, lf[3:0]} + {4'h0, cin};
        e.f    = m ? lf : sum[15:0];
        e.cout = m ? 1'b0 : sum[16];
        e.eq   = (a == b);
        e.cin1 = m ? 1'b0 : lo[4];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input int hold);
        exp_t e;
        int   cyc;
        logic cin1;
        @(posedge clk); #1;
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin; req_valid = 1'b1;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        sb.push_back(model(a, b, s, m, cin));
        #1;
        req_valid = 1'b0;
        // Scramble request inputs: they must be ignored while busy
        req_a = W'($urandom); req_b = W'($urandom); req_s = 4'($urandom);
        req_m = ~m; req_cin = ~cin;
        cyc  = 1;
        cin1 = 1'bx;
        @(negedge clk);
        chk("ula_cin_nib0", 32'(ula_cin), 32'(cin));
        chk("req_ready_run", 32'(req_ready), 32'd0);
        while (!rsp_valid && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 2) cin1 = ula_cin;
        end
        chk("latency", 32'(cyc), 32'(NIB + 1));
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        chk("ula_cin_nib1", 32'(cin1), 32'(e.cin1));
        chk("rsp_f", 32'(rsp_f), 32'(e.f));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        chk("rsp_eq", 32'(rsp_eq), 32'(e.eq));
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                // Competing request while the response is stalled
                req_a = 16'h0F0F; req_b = 16'h0101; req_s = S_ADD_B; req_m = 1'b0;
                req_cin = 1'b0; req_valid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_f", 32'(rsp_f), 32'(e.f));
            chk("hold_cout", 32'(rsp_cout), 32'(e.cout));
            chk("hold_eq", 32'(rsp_eq), 32'(e.eq));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_f", 32'(rsp_f), 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("rst_rsp_eq", 32'(rsp_eq), 32'd0);
        chk("rst_ula_ab", 32'({ula_a, ula_b}), 32'd0);
        chk("rst_ula_smc", 32'({ula_s, ula_m, ula_cin}), 32'd0);

        run_op(16'h00FF, 16'h0001, S_ADD_B,    1'b0, 1'b0, 0);  // add with internal carry chain
        run_op(16'hFFFF, 16'h0001, S_ADD_B,    1'b0, 1'b0, 0);  // overflow -> cout
        run_op(16'h0005, 16'h0003, S_SUB_NOTB, 1'b0, 1'b1, 0);  // subtract
        run_op(16'hA5A5, 16'h0FF0, S_XOR,      1'b1, 1'b0, 0);  // logic XOR
        run_op(16'h1234, 16'h1234, S_ADD_B,    1'b0, 1'b0, 0);  // equal operands
        run_op(16'h1234, 16'h1235, S_XOR,      1'b1, 1'b1, 0);  // differ in LSB
        run_op(16'h8000, 16'h8000, S_ADD_B,    1'b0, 1'b1, 3);  // backpressure
        run_op(16'h0F0F, 16'h0101, S_ADD_B,    1'b0, 1'b0, 0);  // after stall, clean op

        // Reset while RUN is on nibble 2
        @(posedge clk); #1;
        req_a = 16'hCAFE; req_b = 16'h1111; req_s = S_ADD_B; req_m = 1'b0; req_cin = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midop_ula_a", 32'(ula_a), 32'h0A);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ula", 32'({ula_a, ula_b, ula_s, ula_m, ula_cin}), 32'd0);
        repeat (NIB + 2) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_op(16'h7FFF, 16'h0001, S_ADD_B, 1'b0, 1'b0, 0);     // fresh op after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
